// File: rtl/decode_interlock.sv
// Decode-stage interlock: register scoreboard, load-use/WAW stall detection,
// branch flush sequencing and a saturating stall-cycle counter.
module decode_interlock #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_regwrite,
  input  logic             ex_branch_taken,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             id_issue,
  output logic             id_stall,
  output logic             flush,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pending_reg, pending_next;
  logic [31:0]      pend_eff;
  logic [CNT_W-1:0] stall_count_reg, stall_count_next;
  logic             hazard;
  logic             kill;

  // A retiring writeback releases its bit in the same cycle; a new issue to the
  // same register re-arms it, so the set term is OR-ed after the clear.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_score
      assign pend_eff[gi] = pending_reg[gi] & ~(wb_valid & (wb_rd == 5'(gi)));
      if (gi == 0) begin : g_x0
        assign pending_next[gi] = 1'b0;
      end else begin : g_xn
        assign pending_next[gi] = pend_eff[gi] |
                                  (id_issue & id_regwrite & (id_rd == 5'(gi)));
      end
    end
  endgenerate

  assign hazard = (id_uses_rs1 & pend_eff[id_rs1]) |
                  (id_uses_rs2 & pend_eff[id_rs2]) |
                  (id_regwrite & (id_rd != 5'd0) & pend_eff[id_rd]);

  assign kill = ex_branch_taken | (state_reg == FLUSH);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      pending_reg     <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pending_reg     <= pending_next;
      stall_count_reg <= stall_count_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = RUN;
    if (ex_branch_taken) begin
      state_next = FLUSH;
    end else if (id_stall) begin
      state_next = STALL;
    end
  end

  // Output logic
  always_comb begin
    id_issue = id_valid & ~hazard & ~kill;
    id_stall = id_valid &  hazard & ~kill;
    flush    = kill;
  end

  always_comb begin
    stall_count_next = stall_count_reg;
    if (id_stall && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_next = stall_count_reg + 1'b1;
    end
  end

  assign pending     = pending_reg;
  assign stall_count = stall_count_reg;

endmodule
